sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port arbiter that shares the 68K-style SDRAM controller (asn/udsn/ldsn/rw strobe interface, 24-bit word address) between requester A (CPU) and requester B (DMA/video). Each requester uses a req/ack handshake. The arbiter grants one request at a time, round-robin, and drives the controller strobes for a fixed window that covers a worst-case refresh plus access. Read data is captured at the end of the window. Sits between the requesters and the SDRAM controller, all in the clk100_mhz domain.

## Interface
- ACCESS_CYCLES, 18: cycles m_asn is held low per access. Must be ≥16 (refresh 7 + access 8 + 1 alignment).
- GAP_CYCLES, 2: cycles with all strobes high after each access, ≥1.
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = port A always wins.
- clk100_mhz  in  1  clock. Already decided.
- rst  in  1  reset, synchronous, active-high. Already decided.
- a_req  in  1  port A request, level.
- a_we  in  1  1 = write.
- a_be  in  2  byte enables, [1] = upper byte.
- a_addr  in  24  word address.
- a_din  in  16  write data.
- a_ack  out  1  one-cycle completion pulse.
- a_dout  out  16  read data, held until the next port-A read completes.
- b_req, b_we, b_be, b_addr, b_din, b_ack, b_dout: same as port A, for port B.
- m_addr  out  24  to controller addr.
- m_din  out  16  to controller din.
- m_dout  in  16  from controller dout.
- m_asn, m_udsn, m_ldsn  out  1 each  active-low strobes.
- m_rw  out  1  1 = read.

## Operation
- States: IDLE, ACCESS, GAP, NULLW.
- IDLE:
  - If either req is high, grant one port.
  - The granted port's addr, din, we and be are latched into m_addr, m_din, m_rw and an internal be register.
  - The cycle counter is loaded with ACCESS_CYCLES-1.
  - Go to ACCESS and drive m_asn=0 next cycle.
- Grant choice:
  - Only one req high: that port wins.
  - Both high, ROUND_ROBIN=1: grant the port not served last. The last-served flag resets to B, so A wins the first tie.
  - Both high, ROUND_ROBIN=0: A wins.
- Strobes:
  - Read: m_udsn=m_ldsn=0 regardless of be. The controller always returns both bytes.
  - Write: m_udsn=~be[1], m_ldsn=~be[0].
  - m_asn and the ds strobes change on the same edge.
- Write with be=00:
  - Never presented to the controller. Asn low with both ds high would stall it.
  - Goes to NULLW with strobes kept high.
  - Ack pulses on the next cycle, then the block enters GAP.
- ACCESS:
  - Decrement the counter each cycle.
  - At counter 0: on a read, capture m_dout into the granted port's dout register.
  - Same edge: ack that port, set all strobes high, load the counter with GAP_CYCLES-1, go to GAP.
- GAP: counts down with strobes high, then returns to IDLE.
- Outputs are stable for the whole of ACCESS: m_addr, m_din, m_rw and the strobes do not change mid-access.
- Requesters must hold addr/din/we/be stable from req rise until ack. They are latched at grant, but req can be sampled on any IDLE cycle.
- req is level-sensitive: req still high in IDLE after an ack is a new request. A requester wanting one access drops req the cycle after ack.
- Reset values: m_asn=m_udsn=m_ldsn=1, m_rw=1, m_addr=0, m_din=0, a_ack=b_ack=0, a_dout=b_dout=0, state IDLE, last-served=B.
- Reset mid-access: the state is abandoned and the strobes are high on the next cycle. No ack is issued. The controller itself is reset by the same rst.

## Timing
- Read/write: req high at edge k (IDLE) → m_asn low after edge k for exactly ACCESS_CYCLES cycles.
- ack high after edge k+ACCESS_CYCLES, for one cycle, together with m_asn returning high.
- a_dout/b_dout are valid in the ack cycle.
- Null write: ack high after edge k+1.
- Minimum spacing between grants: ACCESS_CYCLES+GAP_CYCLES+1 cycles (default 21).
- Worst-case latency for a port under contention: 2×(ACCESS_CYCLES+GAP_CYCLES+1) cycles.
- m_dout is sampled on the final ACCESS cycle. The controller has its data registered by then for any ACCESS_CYCLES ≥16.

## Test plan
- Single read: a_req with a_addr=0x012345, controller model returns 0xBEEF → m_asn low 18 cycles, m_udsn=m_ldsn=0, m_rw=1, a_ack one pulse at k+18, a_dout=0xBEEF.
- Byte write: b_req with b_we=1, b_be=10, b_din=0x5A00 → m_udsn=0, m_ldsn=1, m_rw=0, m_din=0x5A00 stable for all 18 cycles, b_ack pulse, a_ack stays 0.
- Contention: a_req and b_req held high continuously → grants alternate A,B,A,B with 21-cycle spacing. With ROUND_ROBIN=0 → A only, B starved while A holds req.
- Null write: a_we=1, a_be=00 → m_asn never low, a_ack at k+1, next grant no earlier than GAP later.
- Reset mid-access: rst at ACCESS cycle 9 → strobes high the next cycle, no ack, a_dout=0, a_req afterwards gets a full 18-cycle access.
- Back-to-back single port: a_req held through ack → second access starts exactly GAP_CYCLES+1 cycles after ack, a_dout updates only on the second ack.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of the 68K-style SDRAM controller.
// Each grant holds the strobes for a fixed window covering refresh plus access.
module sdram_arbiter #(
   parameter int ACCESS_CYCLES = 18,
   parameter int GAP_CYCLES    = 2,
   parameter int ROUND_ROBIN   = 1
) (
   input  logic        clk100_mhz,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [1:0]  a_be,
   input  logic [23:0] a_addr,
   input  logic [15:0] a_din,
   output logic        a_ack,
   output logic [15:0] a_dout,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [1:0]  b_be,
   input  logic [23:0] b_addr,
   input  logic [15:0] b_din,
   output logic        b_ack,
   output logic [15:0] b_dout,
   output logic [23:0] m_addr,
   output logic [15:0] m_din,
   input  logic [15:0] m_dout,
   output logic        m_asn,
   output logic        m_udsn,
   output logic        m_ldsn,
   output logic        m_rw
);
   localparam int CNT_W = $clog2(ACCESS_CYCLES + GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, GAP, NULLW} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [23:0]      addr_reg, addr_next;
   logic [15:0]      din_reg, din_next;
   logic             rw_reg, rw_next;
   logic [1:0]       be_reg, be_next;
   logic             grant_b_reg, grant_b_next;
   logic             last_b_reg, last_b_next;
   logic             a_ack_reg, a_ack_next;
   logic             b_ack_reg, b_ack_next;
   logic [15:0]      a_dout_reg, a_dout_next;
   logic [15:0]      b_dout_reg, b_dout_next;

   logic             pick_b;
   logic             sel_we;
   logic [1:0]       sel_be;
   logic             in_access;

   // B wins when alone, or on a tie when round-robin is on and A was served last
   assign pick_b = b_req && (!a_req || ((ROUND_ROBIN != 0) && !last_b_reg));
   assign sel_we = pick_b ? b_we : a_we;
   assign sel_be = pick_b ? b_be : a_be;

   always_ff @(posedge clk100_mhz) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         din_reg     <= '0;
         rw_reg      <= 1'b1;
         be_reg      <= '0;
         grant_b_reg <= 1'b0;
         last_b_reg  <= 1'b1;
         a_ack_reg   <= 1'b0;
         b_ack_reg   <= 1'b0;
         a_dout_reg  <= '0;
         b_dout_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         addr_reg    <= addr_next;
         din_reg     <= din_next;
         rw_reg      <= rw_next;
         be_reg      <= be_next;
         grant_b_reg <= grant_b_next;
         last_b_reg  <= last_b_next;
         a_ack_reg   <= a_ack_next;
         b_ack_reg   <= b_ack_next;
         a_dout_reg  <= a_dout_next;
         b_dout_reg  <= b_dout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      addr_next    = addr_reg;
      din_next     = din_reg;
      rw_next      = rw_reg;
      be_next      = be_reg;
      grant_b_next = grant_b_reg;
      last_b_next  = last_b_reg;
      a_ack_next   = 1'b0;
      b_ack_next   = 1'b0;
      a_dout_next  = a_dout_reg;
      b_dout_next  = b_dout_reg;
      case (state_reg)
         IDLE: begin
            if (a_req || b_req) begin
               grant_b_next = pick_b;
               last_b_next  = pick_b;
               addr_next    = pick_b ? b_addr : a_addr;
               din_next     = pick_b ? b_din : a_din;
               rw_next      = ~sel_we;
               be_next      = sel_be;
               cnt_next     = ACCESS_LOAD;
               // A write with no byte lanes would stall the controller; skip it
               state_next   = (sel_we && (sel_be == 2'b00)) ? NULLW : ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_reg == '0) begin
               if (rw_reg) begin
                  if (grant_b_reg) b_dout_next = m_dout;
                  else             a_dout_next = m_dout;
               end
               a_ack_next = ~grant_b_reg;
               b_ack_next = grant_b_reg;
               cnt_next   = GAP_LOAD;
               state_next = GAP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         NULLW: begin
            a_ack_next = ~grant_b_reg;
            b_ack_next = grant_b_reg;
            cnt_next   = GAP_LOAD;
            state_next = GAP;
         end
         GAP: begin
            if (cnt_reg == '0) state_next = IDLE;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Strobes decode straight from registered state, so asn and ds move together
   assign in_access = (state_reg == ACCESS);
   assign m_asn     = ~in_access;
   assign m_udsn    = ~(in_access && (rw_reg || be_reg[1]));
   assign m_ldsn    = ~(in_access && (rw_reg || be_reg[0]));
   assign m_rw      = rw_reg;
   assign m_addr    = addr_reg;
   assign m_din     = din_reg;
   assign a_ack     = a_ack_reg;
   assign b_ack     = b_ack_reg;
   assign a_dout    = a_dout_reg;
   assign b_dout    = b_dout_reg;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a round-robin instance under full checking
// plus a fixed-priority instance sharing its inputs for the starvation case.
module tb_sdram_arbiter;
   localparam int ACCESS_CYCLES = 18;
   localparam int GAP_CYCLES    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [1:0]  a_be, b_be;
   logic [23:0] a_addr, b_addr;
   logic [15:0] a_din, b_din;
   logic        a_ack, b_ack;
   logic [15:0] a_dout, b_dout;
   logic [23:0] m_addr;
   logic [15:0] m_din, m_dout;
   logic        m_asn, m_udsn, m_ldsn, m_rw;

   logic        f_a_ack, f_b_ack;
   logic [15:0] f_a_dout, f_b_dout;
   logic [23:0] f_m_addr;
   logic [15:0] f_m_din;
   logic        f_m_asn, f_m_udsn, f_m_ldsn, f_m_rw;

   logic [15:0] read_val = 16'h0000;
   logic [15:0] exp_a_dout, exp_b_dout;
   int          low_cnt = 0;
   int          f_a_cnt = 0, f_b_cnt = 0;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   sdram_arbiter #(.ACCESS_CYCLES(ACCESS_CYCLES), .GAP_CYCLES(GAP_CYCLES), .ROUND_ROBIN(1)) dut (
      .clk100_mhz(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_ack(a_ack), .a_dout(a_dout),
      .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
      .b_ack(b_ack), .b_dout(b_dout),
      .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
      .m_asn(m_asn), .m_udsn(m_udsn), .m_ldsn(m_ldsn), .m_rw(m_rw)
   );

   sdram_arbiter #(.ACCESS_CYCLES(ACCESS_CYCLES), .GAP_CYCLES(GAP_CYCLES), .ROUND_ROBIN(0)) dut_fixed (
      .clk100_mhz(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_ack(f_a_ack), .a_dout(f_a_dout),
      .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
      .b_ack(f_b_ack), .b_dout(f_b_dout),
      .m_addr(f_m_addr), .m_din(f_m_din), .m_dout(m_dout),
      .m_asn(f_m_asn), .m_udsn(f_m_udsn), .m_ldsn(f_m_ldsn), .m_rw(f_m_rw)
   );

   // Controller model: data is only valid during the final cycle of the window
   always @(posedge clk) begin
      if (m_asn) low_cnt <= 0;
      else       low_cnt <= low_cnt + 1;
      if (f_a_ack) f_a_cnt <= f_a_cnt + 1;
      if (f_b_ack) f_b_cnt <= f_b_cnt + 1;
   end
   assign m_dout = (low_cnt == ACCESS_CYCLES - 1) ? read_val : 16'h0BAD;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after the grant edge; returns just after the ack edge.
   task automatic observe_access(input string tag, input logic is_b, input logic [23:0] addr,
                                 input logic we, input logic [1:0] be, input logic [15:0] din,
                                 input logic [15:0] rdata);
      int   bad_bus = 0, bad_ack = 0, bad_hold = 0;
      logic eu, el;
      eu = we ? ~be[1] : 1'b0;
      el = we ? ~be[0] : 1'b0;
      read_val = rdata;
      for (int c = 0; c < ACCESS_CYCLES; c++) begin
         if (m_asn !== 1'b0 || m_udsn !== eu || m_ldsn !== el || m_rw !== !we ||
             m_addr !== addr || m_din !== din) bad_bus++;
         if (a_ack !== 1'b0 || b_ack !== 1'b0) bad_ack++;
         if (a_dout !== exp_a_dout || b_dout !== exp_b_dout) bad_hold++;
         tick();
      end
      check({tag, "_bus"}, bad_bus, 0);
      check({tag, "_early_ack"}, bad_ack, 0);
      check({tag, "_dout_hold"}, bad_hold, 0);
      if (!we) begin
         if (is_b) exp_b_dout = rdata;
         else      exp_a_dout = rdata;
      end
      check({tag, "_strobes_off"}, {m_asn, m_udsn, m_ldsn}, 3'b111);
      check({tag, "_ack"}, {a_ack, b_ack}, is_b ? 2'b01 : 2'b10);
      check({tag, "_a_dout"}, a_dout, exp_a_dout);
      check({tag, "_b_dout"}, b_dout, exp_b_dout);
      $display("access %s port=%s addr=%h we=%0d be=%b a_dout=%h b_dout=%h",
               tag, is_b ? "B" : "A", addr, we, be, a_dout, b_dout);
   endtask

   // From just after an ack edge: strobes must stay high through the gap,
   // then the next edge is the earliest legal grant.
   task automatic gap_wait(input string tag);
      int bad = 0;
      for (int g = 0; g < GAP_CYCLES; g++) begin
         tick();
         if (m_asn !== 1'b1) bad++;
      end
      check({tag, "_gap"}, bad, 0);
      tick();
   endtask

   initial begin
      int sa, sb;
      rst = 1'b1;
      a_req = 0; a_we = 0; a_be = 2'b11; a_addr = '0; a_din = '0;
      b_req = 0; b_we = 0; b_be = 2'b11; b_addr = '0; b_din = '0;
      exp_a_dout = 16'h0000; exp_b_dout = 16'h0000;
      repeat (3) tick();
      check("reset_strobes", {m_asn, m_udsn, m_ldsn, m_rw}, 4'b1111);
      check("reset_addr_din", {m_addr, m_din}, 40'h0);
      check("reset_ack_dout", {a_ack, b_ack, a_dout, b_dout}, 34'h0);
      rst = 1'b0;
      tick();

      // Single read on A
      a_req = 1; a_we = 0; a_be = 2'b11; a_addr = 24'h012345; a_din = 16'h0000;
      tick();
      observe_access("read_a", 1'b0, 24'h012345, 1'b0, 2'b11, 16'h0000, 16'hBEEF);
      a_req = 0;
      repeat (4) tick();

      // Upper-byte write on B
      b_req = 1; b_we = 1; b_be = 2'b10; b_addr = 24'h00ABCD; b_din = 16'h5A00;
      tick();
      observe_access("write_b", 1'b1, 24'h00ABCD, 1'b1, 2'b10, 16'h5A00, 16'h1357);
      b_req = 0;
      repeat (4) tick();

      // Contention: B was served last, so A leads and grants alternate
      sa = f_a_cnt; sb = f_b_cnt;
      a_req = 1; a_we = 0; a_be = 2'b11; a_addr = 24'h000010; a_din = 16'h0000;
      b_req = 1; b_we = 0; b_be = 2'b11; b_addr = 24'h000020; b_din = 16'h0000;
      tick();
      observe_access("rr1_a", 1'b0, 24'h000010, 1'b0, 2'b11, 16'h0000, 16'hA001);
      gap_wait("rr1");
      observe_access("rr2_b", 1'b1, 24'h000020, 1'b0, 2'b11, 16'h0000, 16'hB001);
      gap_wait("rr2");
      observe_access("rr3_a", 1'b0, 24'h000010, 1'b0, 2'b11, 16'h0000, 16'hA002);
      gap_wait("rr3");
      observe_access("rr4_b", 1'b1, 24'h000020, 1'b0, 2'b11, 16'h0000, 16'hB002);
      a_req = 0; b_req = 0;
      repeat (4) tick();
      check("fixed_prio_a_grants", f_a_cnt - sa, 4);
      check("fixed_prio_b_grants", f_b_cnt - sb, 0);

      // Null write on A, then B must wait out the gap
      a_req = 1; a_we = 1; a_be = 2'b00; a_addr = 24'h000100; a_din = 16'h1234;
      tick();
      check("nullw_no_strobe", {m_asn, m_udsn, m_ldsn, a_ack}, 4'b1110);
      tick();
      check("nullw_ack", {m_asn, a_ack, b_ack}, 3'b110);
      $display("access nullw port=A addr=%h we=1 be=00 a_ack=%0d", a_addr, a_ack);
      a_req = 0;
      b_req = 1; b_we = 0; b_be = 2'b11; b_addr = 24'h000200; b_din = 16'h0000;
      gap_wait("nullw");
      observe_access("after_nullw_b", 1'b1, 24'h000200, 1'b0, 2'b11, 16'h0000, 16'h4242);
      b_req = 0;
      repeat (4) tick();

      // Reset in the 9th access cycle abandons the access without an ack
      a_req = 1; a_we = 0; a_be = 2'b11; a_addr = 24'h000777; a_din = 16'h0000;
      tick();
      repeat (8) tick();
      check("mid_access_asn", m_asn, 1'b0);
      rst = 1'b1;
      b_req = 1; b_we = 0; b_be = 2'b11; b_addr = 24'h000888; b_din = 16'h0000;
      tick();
      exp_a_dout = 16'h0000; exp_b_dout = 16'h0000;
      check("rst_strobes", {m_asn, m_udsn, m_ldsn}, 3'b111);
      check("rst_no_ack", {a_ack, b_ack}, 2'b00);
      check("rst_a_dout", a_dout, 16'h0000);
      $display("access reset_abort port=A addr=000777 a_ack=%0d", a_ack);
      rst = 1'b0;
      tick();
      observe_access("post_rst_a", 1'b0, 24'h000777, 1'b0, 2'b11, 16'h0000, 16'h7777);
      a_req = 0;
      gap_wait("post_rst");
      observe_access("post_rst_b", 1'b1, 24'h000888, 1'b0, 2'b11, 16'h0000, 16'h8888);
      b_req = 0;
      repeat (4) tick();

      // Back-to-back on A with req held through ack
      a_req = 1; a_we = 0; a_be = 2'b11; a_addr = 24'h00CAFE; a_din = 16'h0000;
      tick();
      observe_access("b2b_1", 1'b0, 24'h00CAFE, 1'b0, 2'b11, 16'h0000, 16'h1111);
      gap_wait("b2b");
      observe_access("b2b_2", 1'b0, 24'h00CAFE, 1'b0, 2'b11, 16'h0000, 16'h2222);
      a_req = 0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
